// File: rtl/wdet_pkg.sv
// rtl/wdet_pkg.sv - shared types, defaults and width helper for the word detect smoother
//
// Contents:
//   wdet_state_e   FSM state encoding (IDLE, ACTIVE, HOLD)
//   DEF_*          default parameter values for word_detect_smoother
//   cnt_w()        bits needed to hold the values 0..max_val (never less than 1)
package wdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } wdet_state_e;

  localparam int DEF_WIN     = 8;
  localparam int DEF_ON_TH   = 6;
  localparam int DEF_OFF_TH  = 2;
  localparam int DEF_HOLDOFF = 4;
  localparam int DEF_CW      = 8;
  localparam int DEF_TIMEOUT = 100000;

  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/wdet_window.sv
// rtl/wdet_window.sv - sliding decision window with incremental vote count
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   shift_en     a new decision is available this cycle
//   bit_in       the decision to shift in
//   flush        clear window bits, fill and count (never asserted with shift_en)
//   next_count   vote count as it will be after this cycle's update
//   full         window will hold WIN decisions after this cycle's update
//   vote_count   registered vote count
module wdet_window #(
  parameter int WIN  = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            shift_en,
  input  logic            bit_in,
  input  logic            flush,
  output logic [CNTW-1:0] next_count,
  output logic            full,
  output logic [CNTW-1:0] vote_count
);

  localparam logic [CNTW-1:0] FILL_MAX = CNTW'(WIN);

  logic [WIN-1:0]  win_q, win_d;
  logic [CNTW-1:0] fill_q, fill_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] drop_bit;

  // The oldest bit only leaves the count once the window is full; before
  // that the top of the shift register is still an empty slot.
  assign drop_bit = (fill_q == FILL_MAX) ? CNTW'(win_q[WIN-1]) : '0;

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (flush) begin
      win_d   = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      win_d   = {win_q[WIN-2:0], bit_in};
      count_d = count_q + CNTW'(bit_in) - drop_bit;
      if (fill_q != FILL_MAX) fill_d = fill_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q   <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  assign next_count = count_d;
  assign full       = (fill_d == FILL_MAX);
  assign vote_count = count_q;

endmodule

// File: rtl/word_detect_smoother.sv
// rtl/word_detect_smoother.sv - majority-vote smoother with hysteresis and hold-off for word decisions
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   result_dv     one-cycle strobe, result is valid
//   result        decision (1 = word, 0 = garbage/silence)
//   detect        one-cycle pulse on word onset
//   word_active   high while a word is active
//   vote_count    number of 1s in the window
//   event_count   saturating count of detect pulses
//   timeout       one-cycle pulse on idle flush
//
// Optional feature macro: WDET_TIMEOUT_EN (idle flush after TIMEOUT cycles
// without a strobe). Without it the window persists and timeout stays 0.
module word_detect_smoother
  import wdet_pkg::*;
#(
  parameter int WIN     = DEF_WIN,
  parameter int ON_TH   = DEF_ON_TH,
  parameter int OFF_TH  = DEF_OFF_TH,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     result_dv,
  input  logic                     result,
  output logic                     detect,
  output logic                     word_active,
  output logic [$clog2(WIN+1)-1:0] vote_count,
  output logic [CW-1:0]            event_count,
  output logic                     timeout
);

  localparam int CNTW = $clog2(WIN+1);
  localparam int HW   = cnt_w(HOLDOFF);

  localparam logic [CNTW-1:0] ON_C   = CNTW'(ON_TH);
  localparam logic [CNTW-1:0] OFF_C  = CNTW'(OFF_TH);
  localparam logic [HW-1:0]   HOLD_C = HW'(HOLDOFF);
  localparam logic [CW-1:0]   EV_MAX = '1;

  if (WIN < 2 || WIN > 32) begin : g_bad_win
    $fatal(1, "word_detect_smoother: WIN must be in 2..32");
  end
  if (!(OFF_TH < ON_TH && ON_TH <= WIN)) begin : g_bad_th
    $fatal(1, "word_detect_smoother: need OFF_TH < ON_TH <= WIN");
  end
  if (HOLDOFF < 0 || CW < 1 || TIMEOUT < 1) begin : g_bad_misc
    $fatal(1, "word_detect_smoother: bad HOLDOFF, CW or TIMEOUT");
  end

  logic [CNTW-1:0] next_count;
  logic            win_full;
  logic            flush;

  wdet_window #(
    .WIN  (WIN),
    .CNTW (CNTW)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (result_dv),
    .bit_in     (result),
    .flush      (flush),
    .next_count (next_count),
    .full       (win_full),
    .vote_count (vote_count)
  );

`ifdef WDET_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_q;

  // A strobe on the expiry cycle suppresses the flush and restarts the count.
  assign flush = !result_dv && (idle_q == IDLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (result_dv || flush) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  assign flush = 1'b0;
`endif

  wdet_state_e   state_q;
  logic [HW-1:0] hold_q;
  logic          detect_q;
  logic          active_q;
  logic [CW-1:0] event_q;
  logic          timeout_q;

  // The FSM only moves on strobe cycles and judges the window as it will be
  // after this strobe is shifted in (next_count / win_full).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      detect_q  <= 1'b0;
      active_q  <= 1'b0;
      event_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      detect_q  <= 1'b0;
      timeout_q <= flush;
      if (flush) begin
        state_q  <= ST_IDLE;
        hold_q   <= '0;
        active_q <= 1'b0;
      end else if (result_dv) begin
        case (state_q)
          ST_IDLE: begin
            if (next_count >= ON_C) begin
              state_q  <= ST_ACTIVE;
              active_q <= 1'b1;
              detect_q <= 1'b1;
              if (event_q != EV_MAX) event_q <= event_q + CW'(1);
            end
          end
          ST_ACTIVE: begin
            // The off threshold is only trusted once the window is full.
            if (win_full && next_count <= OFF_C) begin
              active_q <= 1'b0;
              if (HOLDOFF == 0) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_HOLD;
                hold_q  <= HOLD_C;
              end
            end
          end
          ST_HOLD: begin
            hold_q <= hold_q - HW'(1);
            if (hold_q <= HW'(1)) state_q <= ST_IDLE;
          end
          default: begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign detect      = detect_q;
  assign word_active = active_q;
  assign event_count = event_q;
  assign timeout     = timeout_q;

endmodule
